// File: rtl/ddr_align_pkg.sv
// Shared types and default parameters for the DDR word aligner.
package ddr_align_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

    localparam int DEF_WIDTH       = 8;
    localparam logic [DEF_WIDTH-1:0] DEF_SYNC_WORD = 8'hA7;
    localparam int DEF_SYNC_PERIOD = 4;
    localparam int DEF_MISS_LIMIT  = 2;

    // beat_cnt counts pairs within one word, 0..WIDTH/2-1
    localparam int BEAT_CNT_W = $clog2(DEF_WIDTH / 2);

    function automatic int beat_cnt_w(input int width);
        return $clog2(width / 2);
    endfunction

endpackage

// File: rtl/ddr_align_outreg.sv
// Single-entry output register for aligned payload words, with a sticky overflow flag.
module ddr_align_outreg
    import ddr_align_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             overflow_o
);

    // valid_o/ready_i: a word transfers on every edge where both are high; while
    // valid_o && !ready_i the held word is stable and any new word is dropped.
    logic stalled;
    assign stalled = valid_o && !ready_i;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            word_o     <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (load && !stalled) begin
                word_o  <= load_word;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (load && stalled) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_word_aligner.sv
// Reassembles 2-lane SDR pairs into WIDTH-bit words, locks on SYNC_WORD framing.
// Define DDR_ALIGN_ODD_SLIP_EN to also search the odd (1-bit slipped) window.
module ddr_word_aligner
    import ddr_align_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int               SYNC_PERIOD = DEF_SYNC_PERIOD,
    parameter int               MISS_LIMIT  = DEF_MISS_LIMIT
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             slip_o,
    output logic             overflow_o
);

    localparam int BW = beat_cnt_w(WIDTH);
    localparam int IW = $clog2(SYNC_PERIOD + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(WIDTH / 2 - 1);
    localparam logic [IW-1:0] SYNC_IDX  = IW'(SYNC_PERIOD);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

    align_state_e    state_q, state_d;
    logic [WIDTH:0]  sr_q, sr_next;
    logic [BW-1:0]   beat_q, beat_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            slip_q, slip_d;
    logic [WIDTH-1:0] even_win, odd_win, cur_win;
    logic            even_match, odd_match;
    logic            load;
    logic            unused_bits;

    // data_i[0] is the earlier bit, so it lands one position above data_i[1]
    assign sr_next    = {sr_q[WIDTH-2:0], data_i[0], data_i[1]};
    assign even_win   = sr_next[WIDTH-1:0];
    assign odd_win    = sr_next[WIDTH:1];
    assign even_match = (even_win == SYNC_WORD);
    assign cur_win    = slip_q ? odd_win : even_win;

`ifdef DDR_ALIGN_ODD_SLIP_EN
    assign odd_match = (odd_win == SYNC_WORD);

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            slip_q <= 1'b0;
        end else begin
            slip_q <= slip_d;
        end
    end

    assign unused_bits = ^sr_q[WIDTH:WIDTH-1];
`else
    assign odd_match   = 1'b0;
    assign slip_q      = 1'b0;
    assign unused_bits = ^{sr_q[WIDTH:WIDTH-1], slip_d};
`endif

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            state_q <= HUNT;
            beat_q  <= '0;
            idx_q   <= '0;
            miss_q  <= '0;
        end else begin
            if (enable) begin
                sr_q <= sr_next;
            end
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        slip_d  = slip_q;
        load    = 1'b0;
        if (enable) begin
            case (state_q)
                HUNT: begin
                    if (even_match || odd_match) begin
                        slip_d  = !even_match;
                        beat_d  = '0;
                        idx_d   = '0;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        if (idx_q == SYNC_IDX) begin
                            idx_d = '0;
                            if (cur_win == SYNC_WORD) begin
                                miss_d = '0;
                            end else if (miss_q == MISS_LAST) begin
                                // miss count restarts so a relock gets the full budget
                                miss_d  = '0;
                                state_d = HUNT;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                            load  = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign locked_o = (state_q == LOCKED);
    assign slip_o   = slip_q;

    ddr_align_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .clk_i      (clk_i),
        .reset      (reset),
        .load       (load),
        .load_word  (cur_win),
        .ready_i    (ready_i),
        .word_o     (word_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

endmodule
